// File: rtl/sm3_msg_pad_if.sv
// Message word stream into the SM3 padder.
//   s_data  : message word, byte 0 at [31:24]
//   s_valid : s_data valid
//   s_last  : final word of the message
//   s_bytes : valid bytes in the last word (0 = 4), left-justified
//   s_ready : word accepted when s_valid && s_ready
// master = word source, slave = sm3_msg_pad.
interface sm3_msg_pad_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_last;
   logic [1:0]  s_bytes;
   logic        s_ready;

   modport master (output s_data, output s_valid, output s_last, output s_bytes,
                   input s_ready);
   modport slave  (input s_data, input s_valid, input s_last, input s_bytes,
                   output s_ready);
endinterface

// File: rtl/sm3_msg_pad.sv
// SM3 message padder and block sequencer for the compression core.
// Collects big-endian message words into 512-bit blocks, appends the 0x80
// marker, zero fill and 64-bit bit length, starts the core per block and
// chains each hashout into the next block. Final digest is strobed once.
//   clk, rstn    : clock, asynchronous active-low reset
//   msg          : word stream (slave modport)
//   cmp_start    : one-cycle start to the core
//   cmp_data     : block, word 0 at [511:480]
//   cmp_hashin   : chaining value {A..H}
//   cmp_hashout  : core result {A..H}
//   cmp_valid    : core result strobe
//   digest       : final hash, held until the next message completes
//   digest_valid : one-cycle strobe when digest updates
//   busy         : high whenever not idle
module sm3_msg_pad #(
   parameter logic [255:0] IV =
      256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e
) (
   input  logic           clk,
   input  logic           rstn,
   sm3_msg_pad_if.slave   msg,
   output logic           cmp_start,
   output logic [511:0]   cmp_data,
   output logic [255:0]   cmp_hashin,
   input  logic [255:0]   cmp_hashout,
   input  logic           cmp_valid,
   output logic [255:0]   digest,
   output logic           digest_valid,
   output logic           busy
);

   typedef enum logic [2:0] {StIdle, StFill, StPad, StIssue, StWait, StDone} state_t;

   state_t         state;
   logic [255:0]   hash_v;
   logic [511:0]   blk;
   logic [4:0]     wcnt;
   logic [63:0]    len;
   logic           marker_pend;
   logic           is_final;
   logic           msg_end;

   logic           accept;
   logic [2:0]     nbytes;
   logic [5:0]     len_inc;
   logic [31:0]    in_word;
   logic [4:0]     wcnt_inc;
   logic [3:0]     blk_idx;

   assign msg.s_ready = (state == StIdle) || (state == StFill);
   assign busy        = (state != StIdle);
   assign cmp_data    = blk;
   assign cmp_hashin  = hash_v;

   always_comb begin
      accept   = msg.s_valid && msg.s_ready;
      nbytes   = (msg.s_bytes == 2'd0) ? 3'd4 : {1'b0, msg.s_bytes};
      len_inc  = msg.s_last ? {nbytes, 3'b000} : 6'd32;
      wcnt_inc = wcnt + 5'd1;
      blk_idx  = 4'd15 - wcnt[3:0];
      // Short last word: the marker lands right after the data, garbage below is dropped.
      in_word  = msg.s_data;
      if (msg.s_last) begin
         case (msg.s_bytes)
            2'd1:    in_word = {msg.s_data[31:24], 8'h80, 16'h0000};
            2'd2:    in_word = {msg.s_data[31:16], 8'h80, 8'h00};
            2'd3:    in_word = {msg.s_data[31:8], 8'h80};
            default: in_word = msg.s_data;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= StIdle;
         hash_v       <= IV;
         blk          <= '0;
         wcnt         <= '0;
         len          <= '0;
         marker_pend  <= 1'b0;
         is_final     <= 1'b0;
         msg_end      <= 1'b0;
         digest       <= '0;
         digest_valid <= 1'b0;
         cmp_start    <= 1'b0;
      end else begin
         cmp_start    <= 1'b0;
         digest_valid <= 1'b0;
         unique case (state)
            StIdle, StFill: begin
               if (accept) begin
                  blk[blk_idx*32 +: 32] <= in_word;
                  wcnt                  <= wcnt_inc;
                  len                   <= len + {58'd0, len_inc};
                  if (msg.s_last) begin
                     msg_end     <= 1'b1;
                     marker_pend <= (nbytes == 3'd4);
                  end
                  if (wcnt_inc == 5'd16) begin
                     is_final  <= 1'b0;
                     cmp_start <= 1'b1;
                     state     <= StIssue;
                  end else if (msg.s_last) begin
                     state <= StPad;
                  end else begin
                     state <= StFill;
                  end
               end
            end
            StPad: begin
               if (wcnt == 5'd16) begin
                  is_final  <= 1'b0;
                  cmp_start <= 1'b1;
                  state     <= StIssue;
               end else if (wcnt == 5'd14 && !marker_pend) begin
                  blk[63:0] <= len;
                  is_final  <= 1'b1;
                  cmp_start <= 1'b1;
                  state     <= StIssue;
               end else begin
                  blk[blk_idx*32 +: 32] <= marker_pend ? 32'h8000_0000 : 32'h0;
                  marker_pend           <= 1'b0;
                  wcnt                  <= wcnt_inc;
               end
            end
            StIssue: state <= StWait;
            StWait: begin
               if (cmp_valid) begin
                  hash_v <= cmp_hashout;
                  blk    <= '0;
                  wcnt   <= '0;
                  if (is_final)     state <= StDone;
                  else if (msg_end) state <= StPad;
                  else              state <= StFill;
               end
            end
            StDone: begin
               digest       <= hash_v;
               digest_valid <= 1'b1;
               hash_v       <= IV;
               len          <= '0;
               msg_end      <= 1'b0;
               is_final     <= 1'b0;
               state        <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sm3_msg_pad.sv
module tb_sm3_msg_pad;

   localparam logic [255:0] IV =
      256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
   localparam logic [255:0] DigAbc =
      256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
   localparam logic [255:0] DigAbcd =
      256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;
   localparam int CoreLat = 67;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           cmp_start;
   logic [511:0]   cmp_data;
   logic [255:0]   cmp_hashin;
   logic [255:0]   cmp_hashout = '0;
   logic           cmp_valid = 1'b0;
   logic [255:0]   digest;
   logic           digest_valid;
   logic           busy;

   sm3_msg_pad_if mif ();

   sm3_msg_pad dut (
      .clk          (clk),
      .rstn         (rstn),
      .msg          (mif),
      .cmp_start    (cmp_start),
      .cmp_data     (cmp_data),
      .cmp_hashin   (cmp_hashin),
      .cmp_hashout  (cmp_hashout),
      .cmp_valid    (cmp_valid),
      .digest       (digest),
      .digest_valid (digest_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [7:0] msg_bytes [0:255];

   // ---------------- SM3 reference ----------------
   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      int m;
      m = n % 32;
      return (x << m) | (x >> (32 - m));
   endfunction

   function automatic logic [31:0] p0(input logic [31:0] x);
      return x ^ rotl(x, 9) ^ rotl(x, 17);
   endfunction

   function automatic logic [31:0] p1(input logic [31:0] x);
      return x ^ rotl(x, 15) ^ rotl(x, 23);
   endfunction

   function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] b);
      logic [31:0] w [0:67];
      logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t, ff, gg;
      for (int j = 0; j < 16; j++) w[j] = b[511 - 32*j -: 32];
      for (int j = 16; j < 68; j++)
         w[j] = p1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 15)) ^ rotl(w[j-13], 7) ^ w[j-6];
      {a, bb, c, d, e, f, g, h} = v;
      for (int j = 0; j < 64; j++) begin
         t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
         ss1 = rotl(rotl(a, 12) + e + rotl(t, j), 7);
         ss2 = ss1 ^ rotl(a, 12);
         ff  = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
         gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
         tt1 = ff + d + ss2 + (w[j] ^ w[j+4]);
         tt2 = gg + h + ss1 + w[j];
         d = c; c = rotl(bb, 9); bb = a; a = tt1;
         h = g; g = rotl(f, 19); f = e; e = p0(tt2);
      end
      return {a, bb, c, d, e, f, g, h} ^ v;
   endfunction

   function automatic logic [255:0] ref_hash(input int n);
      logic [255:0] v;
      logic [511:0] b;
      logic [63:0]  bits;
      logic [7:0]   by;
      int           tot, idx;
      v    = IV;
      bits = 64'(n) * 64'd8;
      tot  = ((n + 9 + 63) / 64) * 64;
      for (int k = 0; k < tot / 64; k++) begin
         for (int i = 0; i < 64; i++) begin
            idx = k*64 + i;
            if (idx < n)             by = msg_bytes[idx];
            else if (idx == n)       by = 8'h80;
            else if (idx >= tot - 8) by = bits[8*(tot - 1 - idx) +: 8];
            else                     by = 8'h00;
            b[511 - 8*i -: 8] = by;
         end
         v = sm3_cf(v, b);
      end
      return v;
   endfunction

   // ---------------- core model ----------------
   logic           core_busy = 1'b0;
   int             core_cnt = 0;
   logic [511:0]   core_blk = '0;
   logic [255:0]   core_hin = '0;
   int             n_starts = 0;
   int             stab_err = 0;
   logic [511:0]   blk_log [0:63];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         core_busy <= 1'b0;
         cmp_valid <= 1'b0;
         core_cnt  <= 0;
      end else begin
         cmp_valid <= 1'b0;
         if (core_busy) begin
            // Stream must be stalled and the block/chain held while the core runs.
            if (mif.s_ready || (core_cnt == CoreLat - 2 &&
                (cmp_data !== core_blk || cmp_hashin !== core_hin)))
               stab_err <= stab_err + 1;
            if (core_cnt == CoreLat - 2) begin
               cmp_valid   <= 1'b1;
               cmp_hashout <= sm3_cf(core_hin, core_blk);
               core_busy   <= 1'b0;
            end else begin
               core_cnt <= core_cnt + 1;
            end
         end else if (cmp_start) begin
            core_busy <= 1'b1;
            core_cnt  <= 0;
            core_blk  <= cmp_data;
            core_hin  <= cmp_hashin;
            if (n_starts < 64) blk_log[n_starts] <= cmp_data;
            n_starts  <= n_starts + 1;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] d, input bit last, input logic [1:0] nb);
      int tmo;
      mif.s_data  = d;
      mif.s_last  = last;
      mif.s_bytes = nb;
      mif.s_valid = 1'b1;
      tmo = 0;
      while (!mif.s_ready && tmo < 2000) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 2000) check("ready_timeout", 512'(0), 512'(1));
      @(negedge clk);
   endtask

   task automatic send_msg(input int n, input bit hold, input bit garb);
      int nw, nb;
      logic [31:0] d;
      nw = (n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         nb = (w == nw - 1) ? n - 4*w : 4;
         for (int k = 0; k < 4; k++)
            d[31 - 8*k -: 8] = (k < nb) ? msg_bytes[4*w + k] : (garb ? 8'hee : 8'h00);
         send_word(d, w == nw - 1, (nb == 4) ? 2'd0 : 2'(nb));
         if (!hold && w != nw - 1) begin
            mif.s_valid = 1'b0;
            @(negedge clk);
         end
      end
      mif.s_valid = 1'b0;
      mif.s_last  = 1'b0;
   endtask

   task automatic wait_digest(input logic [255:0] exp);
      int tmo;
      tmo = 0;
      while (!digest_valid && tmo < 2000) begin
         @(negedge clk);
         tmo++;
      end
      check("digest_seen", 512'(digest_valid), 512'(1));
      check("digest", 512'(digest), 512'(exp));
      @(negedge clk);
      check("digest_strobe_1cyc", 512'(digest_valid), 512'(0));
      check("idle_after", 512'(busy), 512'(0));
   endtask

   task automatic fill_pattern(input int n);
      for (int i = 0; i < n; i++) msg_bytes[i] = 8'h61 + 8'(i % 4);
   endtask

   typedef struct {
      int          n;
      bit          hold;
      bit          garb;
      int          starts;
      logic [255:0] dig;
      int          b0, w0;
      logic [31:0] v0;
      int          b1, w1;
      logic [31:0] v1;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int base;
      logic [255:0] exp_dig;
      logic [511:0] tmp;
      int tmo;
      logic [511:0] blk2_exp;

      vecs[0] = '{3,  0, 1, 1, DigAbc,  0, 0,  32'h61626380, 0, 15, 32'h00000018};
      vecs[1] = '{64, 1, 0, 2, DigAbcd, 1, 0,  32'h80000000, 1, 15, 32'h00000200};
      vecs[2] = '{56, 0, 0, 2, '0,      0, 14, 32'h80000000, 1, 15, 32'h000001c0};
      vecs[3] = '{55, 0, 1, 1, '0,      0, 13, 32'h61626380, 0, 15, 32'h000001b8};
      vecs[4] = '{80, 1, 1, 2, '0,      1, 4,  32'h80000000, 1, 15, 32'h00000280};
      vecs[5] = '{1,  0, 1, 1, '0,      0, 0,  32'h61800000, 0, 15, 32'h00000008};

      mif.s_data  = '0;
      mif.s_valid = 1'b0;
      mif.s_last  = 1'b0;
      mif.s_bytes = '0;

      repeat (3) @(negedge clk);
      check("rst_busy", 512'(busy), 512'(0));
      check("rst_ready", 512'(mif.s_ready), 512'(1));
      check("rst_start", 512'(cmp_start), 512'(0));
      check("rst_dvalid", 512'(digest_valid), 512'(0));
      check("rst_digest", 512'(digest), 512'(0));
      check("rst_hashin", 512'(cmp_hashin), 512'(IV));
      check("rst_data", cmp_data, 512'(0));
      rstn = 1'b1;
      @(negedge clk);

      for (int r = 0; r < 6; r++) begin
         fill_pattern(vecs[r].n);
         exp_dig = (vecs[r].dig != '0) ? vecs[r].dig : ref_hash(vecs[r].n);
         base = n_starts;
         send_msg(vecs[r].n, vecs[r].hold, vecs[r].garb);
         wait_digest(exp_dig);
         check("starts", 512'(n_starts - base), 512'(vecs[r].starts));
         tmp = blk_log[base + vecs[r].b0];
         check("blk_word_a", 512'(tmp[511 - 32*vecs[r].w0 -: 32]), 512'(vecs[r].v0));
         tmp = blk_log[base + vecs[r].b1];
         check("blk_word_b", 512'(tmp[511 - 32*vecs[r].w1 -: 32]), 512'(vecs[r].v1));
         check("stall_stable", 512'(stab_err), 512'(0));
      end

      // Whole-block shapes for the boundary messages.
      fill_pattern(3);
      base = n_starts;
      send_msg(3, 0, 0);
      wait_digest(DigAbc);
      check("abc_block", blk_log[base],
            {32'h61626380, 448'd0, 32'h00000018});
      fill_pattern(56);
      base = n_starts;
      send_msg(56, 1, 0);
      wait_digest(ref_hash(56));
      blk2_exp = 512'h1c0;
      check("pad_only_block", blk_log[base + 1], blk2_exp);

      // Reset while the core works on block 1 of a two-block message.
      fill_pattern(64);
      base = n_starts;
      send_msg(64, 1, 0);
      tmo = 0;
      while (n_starts == base && tmo < 500) begin
         @(negedge clk);
         tmo++;
      end
      repeat (10) @(negedge clk);
      check("busy_in_wait", 512'(busy), 512'(1));
      rstn = 1'b0;
      @(negedge clk);
      check("midrst_busy", 512'(busy), 512'(0));
      check("midrst_hashin", 512'(cmp_hashin), 512'(IV));
      check("midrst_dvalid", 512'(digest_valid), 512'(0));
      @(negedge clk);
      rstn = 1'b1;
      base = n_starts;
      repeat (100) @(negedge clk);
      check("no_start_after_rst", 512'(n_starts - base), 512'(0));
      fill_pattern(3);
      send_msg(3, 0, 1);
      wait_digest(DigAbc);
      check("abc_after_rst_starts", 512'(n_starts - base), 512'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
